// File: rtl/merge_pkg.sv
// -----------------------------------------------------------------------------
// merge_pkg
// Shared types and helpers for the merge-router packetizer and the later
// mesh-injection stages.
//   `DW         flit width: {type[1:0], FP32 payload[31:0]}
//   `HEAD/`BODY/`TAIL  2-bit flit type codes
//   flit_type_t flit type enum (values equal the type macros)
//   pkt_state_t packetizer FSM states
//   TYPE_LSB, PAYLOAD_W, HEAD_X_LSB  flit / head-field offsets
//   relu_fp32() clamps negative FP32 values (any sign bit set) to +0.0
// -----------------------------------------------------------------------------
`ifndef DW
`define DW 34
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

package merge_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD = `HEAD,
        FLIT_BODY = `BODY,
        FLIT_TAIL = `TAIL
    } flit_type_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } pkt_state_t;

    // Type field sits on top of the payload; the head packs x, then y, then seq
    // upwards from bit 0 (y and seq offsets scale with the coordinate width).
    localparam int PAYLOAD_W  = `DW - 2;
    localparam int TYPE_LSB   = `DW - 2;
    localparam int HEAD_X_LSB = 0;

    // Negative values, including -0.0 and negative NaNs, become +0.0.
    function automatic logic [31:0] relu_fp32(input logic [31:0] value);
        return value[31] ? 32'h0000_0000 : value;
    endfunction

endpackage

// File: rtl/flit_out_reg.sv
// -----------------------------------------------------------------------------
// flit_out_reg
// Registered valid/ready output stage. A new flit may be loaded whenever the
// register is empty or its current flit is being taken this cycle (load_ok).
// The held flit stays stable until out_valid & out_ready.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            request to load load_data this cycle (honoured if load_ok)
//   load_data [W]   flit to load
//   load_ok         register can accept a flit this cycle
//   out_data  [W]   registered flit
//   out_valid       registered flit valid
//   out_ready       downstream ready
// -----------------------------------------------------------------------------
module flit_out_reg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         load_ok,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign load_ok = ~out_valid | out_ready;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_ok) begin
            out_valid <= load;
            if (load) begin
                out_data <= load_data;
            end
        end
    end

endmodule

// File: rtl/merge_packetizer.sv
// -----------------------------------------------------------------------------
// merge_packetizer
// Groups every PKT_LEN summed FP32 flits from the merge router's local port
// into one wormhole packet: HEAD (dest + seq), PKT_LEN-1 BODY flits, TAIL.
// The HEAD is generated from the IDLE state without consuming an input flit.
// Optional feature: define MERGE_PACKETIZER_RELU_EN to clamp negative payloads
// to +0.0 before the output register (no added latency).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data_i  [`DW]     summed flit; type bits ignored, [`DW-3:0] is the payload
//   valid_i / ready_o input handshake
//   data_o  [`DW]     packet flit {type, payload}
//   valid_o / ready_i output handshake
//   pkt_cnt_o [16]    TAIL flits handed downstream, wrapping
// -----------------------------------------------------------------------------
module merge_packetizer
    import merge_pkg::*;
#(
    parameter int PKT_LEN = 8,
    parameter int DEST_X  = 0,
    parameter int DEST_Y  = 0,
    parameter int COORD_W = 4,
    parameter int SEQ_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [`DW-1:0] data_i,
    input  logic           valid_i,
    output logic           ready_o,
    output logic [`DW-1:0] data_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [15:0]    pkt_cnt_o
);

    localparam int CNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int Y_LSB   = HEAD_X_LSB + COORD_W;
    localparam int SEQ_LSB = Y_LSB + COORD_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

    pkt_state_t           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [SEQ_W-1:0]     seq, seq_n;
    logic                 load, load_ok;
    logic [`DW-1:0]       load_data;
    logic [`DW-1:0]       head_flit;
    logic [PAYLOAD_W-1:0] payload;
    flit_type_t           body_type;
    logic                 unused_type_bits;

    // Incoming type bits carry no meaning here; the packetizer assigns its own.
    assign unused_type_bits = ^data_i[TYPE_LSB +: 2];

`ifdef MERGE_PACKETIZER_RELU_EN
    assign payload = relu_fp32(data_i[PAYLOAD_W-1:0]);
`else
    assign payload = data_i[PAYLOAD_W-1:0];
`endif

    assign body_type = (cnt == LAST_CNT) ? FLIT_TAIL : FLIT_BODY;

    always_comb begin
        head_flit                         = '0;
        head_flit[TYPE_LSB +: 2]          = FLIT_HEAD;
        head_flit[HEAD_X_LSB +: COORD_W]  = COORD_W'(DEST_X);
        head_flit[Y_LSB +: COORD_W]       = COORD_W'(DEST_Y);
        head_flit[SEQ_LSB +: SEQ_W]       = seq;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        seq_n     = seq;
        ready_o   = 1'b0;
        load      = 1'b0;
        load_data = '0;
        unique case (state)
            IDLE: begin
                // Head is emitted on sight of a pending flit; the flit itself
                // stays on the input until PAYLOAD accepts it.
                if (valid_i && load_ok) begin
                    load      = 1'b1;
                    load_data = head_flit;
                    cnt_n     = '0;
                    state_n   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                ready_o = load_ok;
                if (valid_i && load_ok) begin
                    load      = 1'b1;
                    load_data = {body_type, payload};
                    if (cnt == LAST_CNT) begin
                        cnt_n   = '0;
                        seq_n   = seq + SEQ_W'(1);
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            seq   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            seq   <= seq_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_o <= '0;
        end else if (valid_o && ready_i && (data_o[TYPE_LSB +: 2] == FLIT_TAIL)) begin
            pkt_cnt_o <= pkt_cnt_o + 16'd1;
        end
    end

    flit_out_reg #(
        .W(`DW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_ok   (load_ok),
        .out_data  (data_o),
        .out_valid (valid_o),
        .out_ready (ready_i)
    );

endmodule

// File: tb/tb_merge_packetizer.sv
// -----------------------------------------------------------------------------
// tb_merge_packetizer
// Two packetizers share clk/rst: dut (PKT_LEN=4) and dut1 (PKT_LEN=1), both
// addressed to (x=2, y=3). Output and input handshakes are logged at negedge;
// each scenario task compares the logged stream with the packet stream the
// packetizing rules predict from the payloads it sent.
// Build with +define+MERGE_PACKETIZER_RELU_EN to exercise the ReLU variant.
// -----------------------------------------------------------------------------
`ifndef DW
`define DW 34
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module tb_merge_packetizer;

    localparam logic [1:0] T_HEAD = `HEAD;
    localparam logic [1:0] T_BODY = `BODY;
    localparam logic [1:0] T_TAIL = `TAIL;
    localparam int NPKT = 257;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [`DW-1:0] data_i = '0;
    logic           valid_i = 1'b0;
    logic           ready_o;
    logic [`DW-1:0] data_o;
    logic           valid_o;
    logic           ready_i = 1'b1;
    logic [15:0]    pkt_cnt_o;

    logic [`DW-1:0] d1_data_i = '0;
    logic           d1_valid_i = 1'b0;
    logic           d1_ready_o;
    logic [`DW-1:0] d1_data_o;
    logic           d1_valid_o;
    logic           d1_ready_i = 1'b1;
    logic [15:0]    d1_pkt_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_ready = 1'b0;

    logic [`DW-1:0] out_q[$];
    int             out_cyc[$];
    logic [31:0]    in_q[$];
    logic [`DW-1:0] out1_q[$];
    int             out1_cyc[$];
    logic [31:0]    tx_q[$];

    always #5 clk = ~clk;

    merge_packetizer #(
        .PKT_LEN(4), .DEST_X(2), .DEST_Y(3), .COORD_W(4), .SEQ_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .pkt_cnt_o(pkt_cnt_o)
    );

    merge_packetizer #(
        .PKT_LEN(1), .DEST_X(2), .DEST_Y(3), .COORD_W(4), .SEQ_W(8)
    ) dut1 (
        .clk(clk), .rst(rst),
        .data_i(d1_data_i), .valid_i(d1_valid_i), .ready_o(d1_ready_o),
        .data_o(d1_data_o), .valid_o(d1_valid_o), .ready_i(d1_ready_i),
        .pkt_cnt_o(d1_pkt_cnt_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) begin
                out_q.push_back(data_o);
                out_cyc.push_back(cyc);
            end
            if (valid_i && ready_o) in_q.push_back(data_i[31:0]);
            if (d1_valid_o && d1_ready_i) begin
                out1_q.push_back(d1_data_o);
                out1_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [`DW-1:0] exp_head(input int seq);
        logic [31:0] f;
        f = 32'((seq % 256) * 256 + 3 * 16 + 2);
        return {T_HEAD, f};
    endfunction

    function automatic logic [31:0] model_payload(input logic [31:0] v);
`ifdef MERGE_PACKETIZER_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Expected flit k of a stream of 4-payload packets built from list pl,
    // with packet numbering starting at seq0.
    function automatic logic [`DW-1:0] exp_flit(input int k, input int seq0,
                                                  input logic [31:0] pl[$]);
        int pkt, pos;
        pkt = k / 5;
        pos = k % 5;
        if (pos == 0) return exp_head(seq0 + pkt);
        return {(pos == 4) ? T_TAIL : T_BODY, model_payload(pl[pkt * 4 + pos - 1])};
    endfunction

    // ---------------- helpers (stimulus / waiting) ----------------
    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        in_q.delete();
        out1_q.delete();
        out1_cyc.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        valid_i = 1'b0;
        d1_valid_i = 1'b0;
        ready_i = 1'b1;
        d1_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    // Presents each payload of tx_q until accepted; random garbage in type bits.
    task automatic drive_all(input int max_gap);
        int budget;
        while (tx_q.size() > 0) begin
            budget = 0;
            data_i = {2'($urandom), tx_q[0]};
            valid_i = 1'b1;
            @(negedge clk);
            while (!ready_o && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            if (!ready_o) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout: ready_o stayed %0b, required 1 within 200 cycles", ready_o);
                valid_i = 1'b0;
                tx_q.delete();
                return;
            end
            void'(tx_q.pop_front());
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int b;
        b = 0;
        while (out_q.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (out_q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_out: got %0d flits, required %0d", out_q.size(), n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        n_checks += 5;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, exp 0", valid_o); end
        if (data_o !== '0) begin n_fail++; $display("FAIL rst_data: got %h, exp 0", data_o); end
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, exp 0", ready_o); end
        if (pkt_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d, exp 0", pkt_cnt_o); end
        if (d1_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid1: got %b, exp 0", d1_valid_o); end
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b, exp 0", ready_o); end
    endtask

    task automatic test_basic_packet();
        logic [31:0] pl[$];
        pl = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        tx_q = pl;
        ready_i = 1'b1;
        drive_all(0);
        wait_out(5, 50);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5 && k < out_q.size(); k++) begin
            n_checks++;
            if (out_q[k] !== exp_flit(k, 0, pl)) begin
                n_fail++;
                $display("FAIL basic_flit%0d: got %h, exp %h", k, out_q[k], exp_flit(k, 0, pl));
            end
            if (k > 0) begin
                n_checks++;
                if (out_cyc[k] !== out_cyc[k-1] + 1) begin
                    n_fail++;
                    $display("FAIL basic_gap%0d: cycle %0d, exp %0d", k, out_cyc[k], out_cyc[k-1] + 1);
                end
            end
        end
        n_checks++;
        if (pkt_cnt_o !== 16'd1) begin n_fail++; $display("FAIL basic_pkt_cnt: got %0d, exp 1", pkt_cnt_o); end
    endtask

    task automatic test_stall();
        logic [31:0] pl[$];
        logic [`DW-1:0] held;
        bit found;
        int n_in;
        pl = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        clear_logs();
        tx_q = pl;
        found = 1'b0;
        fork
            drive_all(0);
            begin
                for (int k = 0; k < 50 && !found; k++) begin
                    @(posedge clk);
                    #1;
                    if (valid_o && data_o === {T_BODY, 32'h4000_0000}) found = 1'b1;
                end
                if (found) begin
                    ready_i = 1'b0;
                    held = data_o;
                    n_in = in_q.size();
                    repeat (3) begin
                        @(negedge clk);
                        n_checks += 2;
                        if (data_o !== held || valid_o !== 1'b1) begin
                            n_fail++;
                            $display("FAIL stall_hold: got %h/%b, exp %h/1", data_o, valid_o, held);
                        end
                        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b, exp 0", ready_o); end
                        @(posedge clk);
                        #1;
                    end
                    n_checks++;
                    if (in_q.size() !== n_in) begin
                        n_fail++;
                        $display("FAIL stall_consume: accepted %0d, exp %0d", in_q.size(), n_in);
                    end
                    ready_i = 1'b1;
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stall_find: BODY 2.0 not seen, exp within 50 cycles");
                    ready_i = 1'b1;
                end
            end
        join
        wait_out(5, 50);
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q.size() !== 5) begin n_fail++; $display("FAIL stall_count: got %0d flits, exp 5", out_q.size()); end
        for (int k = 0; k < 5 && k < out_q.size(); k++) begin
            n_checks++;
            if (out_q[k] !== exp_flit(k, 1, pl)) begin
                n_fail++;
                $display("FAIL stall_flit%0d: got %h, exp %h", k, out_q[k], exp_flit(k, 1, pl));
            end
        end
        n_checks++;
        if (pkt_cnt_o !== 16'd2) begin n_fail++; $display("FAIL stall_pkt_cnt: got %0d, exp 2", pkt_cnt_o); end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] pl[$];
        int bad;
        apply_reset();
        for (int i = 0; i < NPKT * 4; i++) pl.push_back($urandom);
        tx_q = pl;
        rand_ready = 1'b1;
        drive_all(2);
        wait_out(NPKT * 5, 20000);
        rand_ready = 1'b0;
        #2;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bad = 0;
        for (int k = 0; k < NPKT * 5 && k < out_q.size(); k++) begin
            n_checks++;
            if (out_q[k] !== exp_flit(k, 0, pl)) begin
                n_fail++;
                bad++;
                if (bad <= 20) $display("FAIL wrap_flit%0d: got %h, exp %h", k, out_q[k], exp_flit(k, 0, pl));
            end
        end
        n_checks++;
        if (out_q.size() !== NPKT * 5) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d flits, exp %0d", out_q.size(), NPKT * 5);
        end
        n_checks++;
        if (pkt_cnt_o !== 16'(NPKT)) begin n_fail++; $display("FAIL wrap_pkt_cnt: got %0d, exp %0d", pkt_cnt_o, NPKT); end
    endtask

    task automatic test_pkt_len1();
        logic [31:0] pl[2];
        int b;
        pl = '{32'h40B0_0000, 32'h40C0_0000};
        for (int i = 0; i < 2; i++) begin
            d1_data_i = {2'b00, pl[i]};
            d1_valid_i = 1'b1;
            b = 0;
            @(negedge clk);
            while (!d1_ready_o && b < 20) begin
                @(negedge clk);
                b++;
            end
            @(posedge clk);
            #1;
        end
        d1_valid_i = 1'b0;
        b = 0;
        while (out1_q.size() < 4 && b < 20) begin
            @(negedge clk);
            b++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out1_q.size() !== 4) begin
            n_fail++;
            $display("FAIL len1_count: got %0d flits, exp 4", out1_q.size());
        end else begin
            n_checks += 6;
            if (out1_q[0] !== exp_head(0)) begin n_fail++; $display("FAIL len1_head0: got %h, exp %h", out1_q[0], exp_head(0)); end
            if (out1_q[1] !== {T_TAIL, pl[0]}) begin n_fail++; $display("FAIL len1_tail0: got %h, exp %h", out1_q[1], {T_TAIL, pl[0]}); end
            if (out1_q[2] !== exp_head(1)) begin n_fail++; $display("FAIL len1_head1: got %h, exp %h", out1_q[2], exp_head(1)); end
            if (out1_q[3] !== {T_TAIL, pl[1]}) begin n_fail++; $display("FAIL len1_tail1: got %h, exp %h", out1_q[3], {T_TAIL, pl[1]}); end
            if (out1_cyc[3] !== out1_cyc[0] + 3) begin
                n_fail++;
                $display("FAIL len1_timing: last flit cycle %0d, exp %0d", out1_cyc[3], out1_cyc[0] + 3);
            end
            if (d1_pkt_cnt_o !== 16'd2) begin n_fail++; $display("FAIL len1_pkt_cnt: got %0d, exp 2", d1_pkt_cnt_o); end
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        tx_q = '{32'h3F80_0000, 32'h4000_0000};
        drive_all(0);
        rst = 1'b1;
        #1;
        n_checks += 2;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, exp 0", valid_o); end
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b, exp 0", ready_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        tx_q = '{32'h40E0_0000};
        drive_all(0);
        wait_out(2, 20);
        if (out_q.size() >= 2) begin
            n_checks += 3;
            if (out_q[0] !== exp_head(0)) begin n_fail++; $display("FAIL midrst_head: got %h, exp %h", out_q[0], exp_head(0)); end
            if (out_q[1] !== {T_BODY, 32'h40E0_0000}) begin
                n_fail++;
                $display("FAIL midrst_body: got %h, exp %h", out_q[1], {T_BODY, 32'h40E0_0000});
            end
            if (out_cyc[1] !== out_cyc[0] + 1) begin
                n_fail++;
                $display("FAIL midrst_gap: cycle %0d, exp %0d", out_cyc[1], out_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_relu();
        logic [31:0] exp_p[3];
`ifdef MERGE_PACKETIZER_RELU_EN
        exp_p = '{32'h0000_0000, 32'h0000_0000, 32'h4010_0000};
`else
        exp_p = '{32'hBFC0_0000, 32'h8000_0000, 32'h4010_0000};
`endif
        apply_reset();
        tx_q = '{32'hBFC0_0000, 32'h8000_0000, 32'h4010_0000, 32'h3F80_0000};
        drive_all(0);
        wait_out(5, 50);
        if (out_q.size() >= 5) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (out_q[k+1] !== {T_BODY, exp_p[k]}) begin
                    n_fail++;
                    $display("FAIL relu_flit%0d: got %h, exp %h", k, out_q[k+1], {T_BODY, exp_p[k]});
                end
            end
            n_checks++;
            if (out_q[4] !== {T_TAIL, 32'h3F80_0000}) begin
                n_fail++;
                $display("FAIL relu_tail: got %h, exp %h", out_q[4], {T_TAIL, 32'h3F80_0000});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_stall();
        test_seq_wrap();
        test_pkt_len1();
        test_reset_mid_packet();
        test_relu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
